// File: rtl/shared_link_pkg.sv
// Shared definitions for the shared-link round-robin arbiter.
// Optional tenure watchdog: SHARED_LINK_ARB_TIMEOUT_EN.
package shared_link_pkg;

    localparam int unsigned TENURE_W     = 8;
    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } link_state_e;

endpackage

// File: rtl/shared_link_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module shared_link_rr_pick
    import shared_link_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_winner
);

    int unsigned w_idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_idx = (int'(i_ptr) + off) % N_REQ;
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/shared_link_arb.sv
// Round-robin arbiter for a single shared link with a one-cycle turnaround gap.
// Optional tenure watchdog enabled by defining SHARED_LINK_ARB_TIMEOUT_EN.
module shared_link_arb
    import shared_link_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    localparam int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_done,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_id,
    output logic             o_busy,
    output logic             o_timeout
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("N_REQ out of range 2..8");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX out of range 2..255");
    end

    link_state_e      r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id, w_gnt_id_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic             w_valid;
    logic [ID_W-1:0]  w_winner;
    logic [N_REQ-1:0] w_win_onehot;
    logic [ID_W-1:0]  w_win_next_ptr;
    logic             w_req_g;
    logic             w_done_g;
    logic             w_hit;
    logic             w_release;
    logic             w_forced;

    shared_link_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

`ifdef SHARED_LINK_ARB_TIMEOUT_EN
    logic [TENURE_W-1:0] r_tenure;
    logic [TENURE_W-1:0] w_tenure_inc;

    assign w_tenure_inc = (r_tenure == '1) ? r_tenure : r_tenure + TENURE_W'(1);
    // Fires on the HOLD_MAX-th grant cycle so the grant lasts exactly HOLD_MAX cycles.
    assign w_hit        = (w_tenure_inc >= TENURE_W'(HOLD_MAX));

    // Held at zero outside GRANT, so every tenure starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tenure <= '0;
        end else if (r_state != GRANT) begin
            r_tenure <= '0;
        end else begin
            r_tenure <= w_tenure_inc;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_win_onehot   = N_REQ'(1) << w_winner;
    assign w_win_next_ptr = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    assign w_req_g   = i_req[r_gnt_id];
    assign w_done_g  = i_done[r_gnt_id];
    assign w_release = w_done_g | ~w_req_g | w_hit;
    // A normal release in the same cycle takes precedence over the watchdog.
    assign w_forced  = w_hit & ~w_done_g & w_req_g;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = w_win_onehot;
                    w_gnt_id_nxt = w_winner;
                    w_ptr_nxt    = w_win_next_ptr;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt   = GAP;
                    w_gnt_nxt     = '0;
                    w_timeout_nxt = w_forced;
                end
            end
            GAP: begin
                // Requests are sampled during the gap so the next grant follows it directly.
                if (w_valid) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = w_win_onehot;
                    w_gnt_id_nxt = w_winner;
                    w_ptr_nxt    = w_win_next_ptr;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_busy    = |r_gnt;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_shared_link_arb.sv
// Directed, table-driven bench for shared_link_arb (N_REQ=4, HOLD_MAX=16).
module tb_shared_link_arb;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    localparam int NV = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[NV];

    shared_link_arb #(
        .N_REQ    (4),
        .HOLD_MAX (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_done    (done),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        step();
        rst  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cnt;
        logic [3:0] exp_g;

        //           rst   req      done     gnt      id     busy  to
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0011, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b1110, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'b1110, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'b1001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d gnt_id", i), 32'(gnt_id), 32'(vecs[i].id));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d timeout", i), 32'(timeout), 32'(vecs[i].to));
        end

        // All four requesting, each grantee pulses done in its second grant cycle.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            done  = (i % 3 == 2) ? (4'b0001 << ((i / 3) % 4)) : 4'b0000;
            exp_g = (i % 3 == 2) ? 4'b0000 : (4'b0001 << ((i / 3) % 4));
            step();
            check($sformatf("rr%0d gnt", i), 32'(gnt), 32'(exp_g));
            check($sformatf("rr%0d busy", i), 32'(busy), 32'(exp_g != 4'b0000));
        end
        done = '0;

`ifdef SHARED_LINK_ARB_TIMEOUT_EN
        // Held request with no done: forced release after exactly 16 grant cycles.
        do_reset();
        req = 4'b0010;
        step();
        cnt = 0;
        while (gnt == 4'b0010 && cnt < 40) begin
            cnt++;
            check($sformatf("to_hold%0d timeout", cnt), 32'(timeout), 32'd0);
            step();
        end
        check("to_tenure cycles", 32'(cnt), 32'd16);
        check("to_release gnt", 32'(gnt), 32'd0);
        check("to_release timeout", 32'(timeout), 32'd1);
        step();
        check("to_pulse_end timeout", 32'(timeout), 32'd0);
        check("to_regrant gnt", 32'(gnt), 32'b0010);

        // done lands on the same cycle the watchdog would fire.
        do_reset();
        req = 4'b0001;
        step();
        for (int i = 0; i < 15; i++) step();
        check("dto_last gnt", 32'(gnt), 32'b0001);
        done = 4'b0001;
        step();
        done = '0;
        check("dto gnt", 32'(gnt), 32'd0);
        check("dto timeout", 32'(timeout), 32'd0);
        step();
        check("dto_after timeout", 32'(timeout), 32'd0);
`else
        // Without the watchdog the grant is held indefinitely.
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("hold%0d gnt", i), 32'(gnt), 32'b0010);
            check($sformatf("hold%0d timeout", i), 32'(timeout), 32'd0);
        end
`endif

        req = '0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shared_link_arb.md
SHARED_LINK_ARB -- requirements
Module: shared_link_arb

Interface
- REQ-001: Parameter N_REQ, default 4, number of requesters sharing one m01_m02-style link (range 2..8).
- REQ-002: Parameter HOLD_MAX, default 16, maximum grant tenure in cycles before forced release (range 2..255).
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: req  input  N_REQ  per-requester request; level, held high until done.
- REQ-006: done  input  N_REQ  per-requester end-of-transfer strobe; only the granted bit is honoured.
- REQ-007: gnt  output  N_REQ  one-hot grant, registered; all-zero when link idle.
- REQ-008: gnt_id  output  $clog2(N_REQ)  index of current/last grantee, registered.
- REQ-009: busy  output  1  high while any gnt bit is high.
- REQ-010: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
- REQ-011: FSM states IDLE, GRANT, GAP; exactly one active per cycle.
- REQ-012: IDLE -> GRANT when any req bit is high; gnt asserts the cycle after req is sampled (latency 1 cycle).
- REQ-013: Winner chosen round-robin: first set req bit searching upward from (ptr), wrapping from N_REQ-1 to 0.
- REQ-014: On entering GRANT, ptr updates to (winner+1) mod N_REQ; ptr reset value 0.
- REQ-015: GRANT -> GAP when done[gnt_id] is high, or req[gnt_id] drops, or (timeout feature enabled) tenure counter reaches HOLD_MAX.
- REQ-016: GAP lasts exactly one cycle with gnt all-zero (bus turnaround), then -> IDLE; a pending req is granted the following cycle per REQ-012.
- REQ-017: done bits for non-granted requesters are ignored; done with req low in IDLE is ignored.
- REQ-018: Tenure counter is 8 bits, cleared on entry to GRANT, increments each GRANT cycle, saturates at 255.
- REQ-019: Simultaneous done and timeout condition in one cycle: treat as normal release; timeout stays low.
- REQ-020: New req arriving during GRANT or GAP waits; no preemption of the current grantee.
- REQ-021: gnt never has more than one bit set; busy equals |gnt.

Reset
- REQ-022: rst high forces state IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, tenure=0 on the next edge.
- REQ-023: rst asserted mid-GRANT drops the grant at that edge with no timeout pulse; no transaction state survives reset.

Configuration
- REQ-024: Macro SHARED_LINK_ARB_TIMEOUT_EN defined: tenure watchdog active per REQ-015, timeout pulses on forced release.
- REQ-025: Macro undefined: no forced release, grant held until done or req drop, timeout tied 0, tenure counter not synthesised.

Structure
- REQ-026: Package shared_link_pkg holds the FSM state enum (IDLE, GRANT, GAP), TENURE_W=8, and the default N_REQ/HOLD_MAX constants.
- REQ-027: Sub-module shared_link_rr_pick (combinational: req vector + ptr -> valid, winner index) instantiated once.
- REQ-028: Port list connectable to an interface carrying req/done/gnt; the arbiter itself uses plain ports.

Verification
- REQ-029: Reset then req=4'b0100 -> gnt=4'b0100, gnt_id=2 one cycle later; ptr=3.
- REQ-030: req=4'b1111 held, each grantee pulses done after 2 cycles -> grant order 0,1,2,3,0 with one all-zero GAP cycle between grants.
- REQ-031: Timeout enabled, HOLD_MAX=16, req[1] held with no done -> gnt[1] dropped after 16 GRANT cycles, timeout high exactly 1 cycle.
- REQ-032: Timeout disabled, same stimulus for 100 cycles -> gnt stays 4'b0010, timeout stays 0.
- REQ-033: rst asserted while gnt=4'b1000 -> next cycle gnt=0, busy=0, ptr=0; then req=4'b1001 -> gnt=4'b0001.
- REQ-034: done[2] pulsed while gnt=4'b0001 -> ignored, grant unchanged; done and timeout same cycle -> release with timeout=0.
